// File: rtl/div_remainder_stage_pkg.sv
// Shared parameters and FSM state type for the signed remainder/quotient stage.
package pkg_system_mdr;

  localparam int DW     = 16;
  localparam int N_ITER = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/div_remainder_stage.sv
// Restoring signed divider stage: consumes one shifted divisor per i_flag,
// builds the quotient magnitude, then applies sign fixup and reports the result.
module div_remainder_stage #(
  parameter int DW     = pkg_system_mdr::DW,
  parameter int N_ITER = pkg_system_mdr::N_ITER
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic signed [DW-1:0]  i_dividend,
  input  logic signed [2*DW-1:0] i_divisor,
  input  logic                  i_flag,
  output logic                  o_busy,
  output logic                  o_done,
  output logic signed [DW-1:0]  o_quotient,
  output logic signed [DW-1:0]  o_remainder,
  output logic                  o_div_zero
);

  import pkg_system_mdr::*;

  localparam int CW = $clog2(N_ITER) + 1;

  state_e        state_q, state_d;
  logic [DW:0]   rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dividend_q, dividend_d;
  logic          dvsSign_q, dvsSign_d;
  logic          nonZero_q, nonZero_d;
  logic [DW-1:0] quoOut_q, quoOut_d;
  logic [DW-1:0] remOut_q, remOut_d;
  logic          divZero_q, divZero_d;

  logic [2*DW:0] divExt, divMag, remExt;
  logic [DW:0]   dvdExt, dvdMag, remSub;
  logic [DW-1:0] quoFix, remFix;
  logic          remGeq, quoNeg;

  // Magnitudes are one bit wider than the operands so the most negative value survives.
  always_comb begin
    divExt = {i_divisor[2*DW-1], i_divisor};
    divMag = divExt[2*DW] ? (~divExt + 1'b1) : divExt;
    dvdExt = {i_dividend[DW-1], i_dividend};
    dvdMag = dvdExt[DW] ? (~dvdExt + 1'b1) : dvdExt;
    remExt = {{DW{1'b0}}, rem_q};
    remGeq = (remExt >= divMag);
    remSub = rem_q - divMag[DW:0];
    quoNeg = dividend_q[DW-1] ^ dvsSign_q;
    quoFix = quoNeg ? (~quo_q + 1'b1) : quo_q;
    remFix = dividend_q[DW-1] ? (~rem_q[DW-1:0] + 1'b1) : rem_q[DW-1:0];
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    dvsSign_d  = dvsSign_q;
    nonZero_d  = nonZero_q;
    quoOut_d   = quoOut_q;
    remOut_d   = remOut_q;
    divZero_d  = divZero_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          rem_d      = dvdMag;
          quo_d      = '0;
          cnt_d      = '0;
          dividend_d = i_dividend;
          dvsSign_d  = 1'b0;
          nonZero_d  = 1'b0;
          state_d    = ITER;
        end
      end
      ITER: begin
        if (i_flag) begin
          if (remGeq) begin
            rem_d = remSub;
          end
          quo_d     = {quo_q[DW-2:0], remGeq};
          cnt_d     = cnt_q + 1'b1;
          nonZero_d = nonZero_q | (divMag != '0);
          if (cnt_q == '0) begin
            dvsSign_d = i_divisor[2*DW-1];
          end
          if (cnt_q == CW'(N_ITER - 1)) begin
            state_d = FIXUP;
          end
        end
      end
      FIXUP: begin
        // A divisor that never had any magnitude reports the dividend back untouched.
        if (!nonZero_q) begin
          divZero_d = 1'b1;
          quoOut_d  = '0;
          remOut_d  = dividend_q;
        end else begin
          divZero_d = 1'b0;
          quoOut_d  = quoFix;
          remOut_d  = remFix;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      dividend_q <= '0;
      dvsSign_q  <= 1'b0;
      nonZero_q  <= 1'b0;
      quoOut_q   <= '0;
      remOut_q   <= '0;
      divZero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      dvsSign_q  <= dvsSign_d;
      nonZero_q  <= nonZero_d;
      quoOut_q   <= quoOut_d;
      remOut_q   <= remOut_d;
      divZero_q  <= divZero_d;
    end
  end

  assign o_busy      = (state_q == ITER) || (state_q == FIXUP);
  assign o_done      = (state_q == DONE);
  assign o_quotient  = quoOut_q;
  assign o_remainder = remOut_q;
  assign o_div_zero  = divZero_q;

endmodule

// File: tb/tb_div_remainder_stage.sv
// Scoreboard bench for div_remainder_stage: a driver issues divisions and queues
// arithmetic expectations, a monitor checks each o_done pulse against the queue.
module tb_div_remainder_stage;

  import pkg_system_mdr::*;

  localparam int W   = DW;
  localparam int NI  = N_ITER;
  localparam int DW2 = 2 * DW;

  typedef struct {
    logic signed [W-1:0] q;
    logic signed [W-1:0] r;
    logic                dz;
    int                  doneCyc;
    string               name;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_start;
  logic signed [W-1:0]   i_dividend;
  logic signed [DW2-1:0] i_divisor;
  logic                  i_flag;
  logic                  o_busy;
  logic                  o_done;
  logic signed [W-1:0]   o_quotient;
  logic signed [W-1:0]   o_remainder;
  logic                  o_div_zero;

  exp_t sb[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   cyc     = 0;

  div_remainder_stage #(.DW(W), .N_ITER(NI)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .i_flag     (i_flag),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_quotient (o_quotient),
    .o_remainder(o_remainder),
    .o_div_zero (o_div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint req);
    nChecks++;
    if (act != req) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference result from plain integer division (truncating toward zero).
  task automatic refModel(input int a, input int d, output logic signed [W-1:0] q,
                          output logic signed [W-1:0] r, output logic dz);
    int qi, ri;
    if (d == 0) begin
      qi = 0;
      ri = a;
      dz = 1'b1;
    end else begin
      qi = a / d;
      ri = a % d;
      dz = 1'b0;
    end
    q = qi[W-1:0];
    r = ri[W-1:0];
  endtask

  // Monitor: every o_done pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (o_done) begin
      if (sb.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected_done: got o_done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_quotient"},  longint'(o_quotient),  longint'(e.q));
        checkOutput({e.name, "_remainder"}, longint'(o_remainder), longint'(e.r));
        checkOutput({e.name, "_div_zero"},  longint'(o_div_zero),  longint'(e.dz));
        checkOutput({e.name, "_latency"},   longint'(cyc),         longint'(e.doneCyc));
      end
    end
  end

  // Issues one division. abortAfter >= 0 pulses rst instead of that iteration;
  // pokeStart raises an ignored i_start in the middle of the operation.
  task automatic applyStimulus(input int a, input int d, input int gapPct, input string name,
                               input int abortAfter, input bit pokeStart);
    int   gapsPer[NI];
    int   totalGaps;
    int   startCyc;
    int   t;
    exp_t e;
    totalGaps = 0;
    for (int k = 0; k < NI; k++) begin
      gapsPer[k] = (gapPct > 0 && $urandom_range(99) < gapPct) ? $urandom_range(3, 1) : 0;
      totalGaps += gapsPer[k];
    end
    @(negedge clk);
    i_start   = 1'b0;
    i_flag    = 1'b1;
    i_divisor = DW2'($urandom);
    @(negedge clk);
    i_flag     = 1'b0;
    i_start    = 1'b1;
    i_dividend = W'(a);
    startCyc   = cyc;
    if (abortAfter < 0) begin
      refModel(a, d, e.q, e.r, e.dz);
      e.doneCyc = startCyc + NI + 2 + totalGaps;
      e.name    = name;
      sb.push_back(e);
    end
    for (int k = 0; k < NI; k++) begin
      for (int g = 0; g < gapsPer[k]; g++) begin
        @(negedge clk);
        i_start   = 1'b0;
        i_flag    = 1'b0;
        i_divisor = DW2'($urandom);
      end
      @(negedge clk);
      i_start    = pokeStart && (k == 3);
      i_dividend = W'($urandom);
      i_flag     = 1'b1;
      i_divisor  = DW2'(longint'(d) * (longint'(1) << (NI - 1 - k)));
      if (k == abortAfter) begin
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        i_flag = 1'b0;
        checkOutput({name, "_rst_busy"},      longint'(o_busy),      0);
        checkOutput({name, "_rst_done"},      longint'(o_done),      0);
        checkOutput({name, "_rst_quotient"},  longint'(o_quotient),  0);
        checkOutput({name, "_rst_remainder"}, longint'(o_remainder), 0);
        checkOutput({name, "_rst_div_zero"},  longint'(o_div_zero),  0);
        repeat (NI + 4) @(negedge clk);
        checkOutput({name, "_idle_busy"}, longint'(o_busy), 0);
        return;
      end
    end
    @(negedge clk);
    i_start = 1'b0;
    i_flag  = 1'b0;
    t = 0;
    while (!o_done && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!o_done) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s_timeout: got no o_done within 100 cycles, required a pulse", name);
    end
  endtask

  initial begin
    logic signed [W-1:0] ra, rd;
    int                  a, d;
    rst        = 1'b1;
    i_start    = 1'b0;
    i_flag     = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",      longint'(o_busy),      0);
    checkOutput("reset_done",      longint'(o_done),      0);
    checkOutput("reset_quotient",  longint'(o_quotient),  0);
    checkOutput("reset_remainder", longint'(o_remainder), 0);
    checkOutput("reset_div_zero",  longint'(o_div_zero),  0);
    rst = 1'b0;

    applyStimulus(100,    7,  0, "basic",      -1, 1'b0);
    applyStimulus(-100,   7,  0, "neg_dvd",    -1, 1'b0);
    applyStimulus(100,   -7,  0, "neg_dvs",    -1, 1'b0);
    applyStimulus(-32768, -1, 0, "overflow",   -1, 1'b0);
    applyStimulus(1234,   0,  0, "div_zero",   -1, 1'b0);
    applyStimulus(100,    7, 40, "gaps",       -1, 1'b0);
    applyStimulus(100,    7,  0, "abort",       5, 1'b0);
    applyStimulus(50,     5, 20, "after_rst",  -1, 1'b1);

    for (int n = 0; n < 20; n++) begin
      ra = W'($urandom);
      rd = W'($urandom);
      a  = int'(ra);
      d  = ($urandom_range(9) == 0) ? 0 : (int'(rd) >>> $urandom_range(W - 1));
      applyStimulus(a, d, 20, "random", -1, 1'b0);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", longint'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/div_remainder_stage.md
DIV_REMAINDER_STAGE -- requirements
Module: div_remainder_stage

Interface
REQ-001 Parameters SHALL be: DW, default 16, dividend/quotient/remainder width; N_ITER, default 16, number of compare-subtract iterations.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_start  in  1  request a division; sampled only in IDLE.
REQ-005 i_dividend  in  signed DW  dividend, captured on accepted i_start.
REQ-006 i_divisor  in  signed 2*DW  current shifted divisor from the upstream divisor stage.
REQ-007 i_flag  in  1  upstream shift-valid; i_divisor is valid for one iteration when high.
REQ-008 o_busy  out  1  high in ITER and FIXUP.
REQ-009 o_done  out  1  one-cycle pulse in DONE.
REQ-010 o_quotient  out  signed DW  signed quotient.
REQ-011 o_remainder  out  signed DW  signed remainder.
REQ-012 o_div_zero  out  1  divisor magnitude was zero on every iteration of the last operation.

Function
REQ-013 The FSM SHALL have states IDLE, ITER, FIXUP and DONE, and SHALL enter IDLE after reset.
REQ-014 In IDLE with i_start=1, the block SHALL capture |i_dividend| into a DW+1-bit unsigned remainder, store the dividend sign, clear the quotient and iteration counter, and go to ITER.
REQ-015 In IDLE, i_flag SHALL be ignored; in ITER, FIXUP and DONE, i_start SHALL be ignored.
REQ-016 In ITER with i_flag=1, with D = |i_divisor| as 2*DW+1-bit unsigned:
- if rem >= D: rem <= rem-D, shift 1 into the quotient LSB; otherwise shift 0;
- the counter SHALL increment;
- the divisor sign SHALL be latched from i_divisor[2*DW-1] on the first iteration.
REQ-017 In ITER with i_flag=0, all state SHALL hold, so gaps of any length SHALL NOT change the result.
REQ-018 The iteration with counter = N_ITER-1 and i_flag=1 SHALL move the FSM to FIXUP.
REQ-019 FIXUP SHALL last one cycle:
- quotient negated if dividend sign XOR divisor sign;
- remainder takes the dividend sign;
- both truncated to DW bits in two's complement (-32768/-1 gives quotient -32768).
REQ-020 If D was 0 on every iteration, FIXUP SHALL set o_div_zero=1, o_quotient=0 and o_remainder=i_dividend; otherwise it SHALL clear o_div_zero.
REQ-021 DONE SHALL assert o_done for exactly one cycle and then return to IDLE unconditionally.
REQ-022 o_quotient, o_remainder and o_div_zero SHALL be registered, SHALL change only in FIXUP, and SHALL hold until the next FIXUP.
REQ-023 Latency from accepted i_start to o_done SHALL be N_ITER flag cycles + 2 cycles, plus any cycles where i_flag=0.

Reset
REQ-024 On rst=1 the following SHALL be 0 at the next edge: o_busy, o_done, o_quotient, o_remainder, o_div_zero, the counter and internal remainder/quotient.
REQ-025 rst SHALL take priority over i_start and i_flag.
REQ-026 rst asserted mid-operation SHALL abort to IDLE with no o_done pulse.

Structure
REQ-027 DW, N_ITER and the state enum typedef SHALL live in pkg_system_mdr.
REQ-028 The block SHALL be a single module with no sub-module: one registered FSM/datapath process plus combinational magnitude and compare logic.

Verification
REQ-029 Bench divisor driver: after each i_flag the bench SHALL present i_divisor = Dsigned * 2^(N_ITER-1-k) for iteration k.
REQ-030 Basic: 100 / 7, i_flag continuous -> o_quotient=14, o_remainder=2, o_done exactly 18 cycles after i_start.
REQ-031 Signs:
- -100 / 7 -> quotient -14, remainder -2;
- 100 / -7 -> quotient -14, remainder 2.
REQ-032 Overflow and zero:
- -32768 / -1 -> quotient -32768, remainder 0, o_div_zero=0;
- 1234 / 0 -> o_div_zero=1, quotient 0, remainder 1234.
REQ-033 Flag gaps: 100 / 7 with i_flag low on random cycles -> same result; o_done delayed by exactly the number of gap cycles.
REQ-034 Mid-op reset: rst pulsed at iteration 5 -> outputs 0 next cycle, no o_done. Then i_start during busy is ignored and a following division 50/5 gives 10, 0.
